// File: rtl/tone_gen.sv
// tone_gen -- numerically-controlled tone source feeding the Audio PWM stage.
//
// A phase accumulator advances once per sample period (SAMPLE_DIV clocks).
// From the phase, or from a 16-bit LFSR, one of four waveforms is selected.
// The selection is scaled by amp around midscale (1024) and is presented as an
// unsigned 11-bit sample. The new frequency words are double-buffered so that a
// change only takes effect on a sample boundary.
//
// Ports
//   clk          system clock (100 MHz)
//   rst          asynchronous, active-high reset
//   freq_word    phase increment per sample; f_out = freq_word * Fs / 2^PHASE_W
//   freq_load    one-cycle strobe capturing freq_word into the shadow register
//   wave_sel     0 square, 1 saw, 2 triangle, 3 noise
//   amp          gain in 1/256 units; values above 256 behave as 256
//   enable       1 = run; 0 = hold phase/LFSR and emit midscale
//   value        unsigned 11-bit sample to the PWM stage
//   sample_tick  one-cycle pulse in the first cycle a new value is visible
//
// Pipeline for a divider tick in cycle T:
//   edge T+1  phase / LFSR advance
//   edge T+2  raw waveform selected (wave_sel, enable sampled)
//   edge T+3  value scaled (amp sampled), sample_tick raised
//
// SAMPLE_DIV must be at least 4, so that the pipeline drains before the next tick.
// PHASE_W must be at least 12, so that the triangle has 11 bits below the MSB.

module tone_gen #(
  parameter int SAMPLE_DIV = 2048,
  parameter int PHASE_W    = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_load,
  input  logic [1:0]         wave_sel,
  input  logic [8:0]         amp,
  input  logic               enable,
  output logic [10:0]        value,
  output logic               sample_tick
);

  localparam int              CNT_W    = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam int              P        = PHASE_W - 1;
  localparam logic [10:0]     MID      = 11'd1024;
  localparam logic [15:0]     LFSR_SEED = 16'hACE1;

  // ---------------------------------------------------------------------------
  // Sample-rate divider
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Frequency double buffer
  // A load arriving in a tick cycle is deliberately not seen by that tick: the
  // tick consumes the old pending/shadow, while the load re-arms pending with
  // the new word for the following tick.
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] shadow;
  logic [PHASE_W-1:0] active;
  logic               pending;
  logic [PHASE_W-1:0] inc;

  // A pending word is used directly on its first tick, so the change is not
  // delayed by one extra sample while it moves into active.
  assign inc = pending ? shadow : active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (tick && pending) active <= shadow;
      if (freq_load) begin
        shadow  <= freq_word;
        pending <= 1'b1;
      end else if (tick) begin
        pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: phase accumulator and noise LFSR (both frozen while disabled)
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] phase;
  logic [15:0]        lfsr;
  logic               lfsr_fb;

  // Fibonacci taps 16,14,13,11: maximal length, never reaches zero from a
  // nonzero seed.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      lfsr  <= LFSR_SEED;
    end else if (tick && enable) begin
      phase <= phase + inc;
      lfsr  <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Valid shift register: [0] = stage 2 due, [1] = stage 3 due.
  logic [1:0] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[0], tick};
  end

  // ---------------------------------------------------------------------------
  // Stage 2: waveform selection from the freshly updated phase
  // ---------------------------------------------------------------------------
  logic [10:0] raw;
  logic [10:0] raw_next;

  always_comb begin
    raw_next = MID;
    if (enable) begin
      case (wave_sel)
        2'd0:    raw_next = phase[P] ? 11'd0 : 11'd2047;
        2'd1:    raw_next = phase[P -: 11];
        // Fold the second half of the cycle back down. Inverting gives the
        // mirror image without a subtractor.
        2'd2:    raw_next = phase[P] ? ~phase[P-1 -: 11] : phase[P-1 -: 11];
        default: raw_next = lfsr[15:5];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              raw <= MID;
    else if (vld_pipe[0]) raw <= raw_next;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: amplitude scaling around midscale
  // |d| <= 1024 and gain <= 1, so the result always lands in 0..2047. The
  // 11-bit wrap of MID + scaled is therefore exact, and no clamp is needed.
  // ---------------------------------------------------------------------------
  logic [8:0]         gain;
  logic signed [11:0] d;
  logic signed [21:0] prod;
  logic [10:0]        value_next;

  assign gain       = (amp > 9'd256) ? 9'd256 : amp;
  assign d          = $signed({1'b0, raw}) - 12'sd1024;
  assign prod       = $signed({{10{d[11]}}, d}) * $signed({13'd0, gain});
  assign value_next = MID + 11'(prod >>> 8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value       <= MID;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= vld_pipe[1];
      if (vld_pipe[1]) value <= value_next;
    end
  end

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen -- directed self-checking bench for tone_gen.
// The bench runs with SAMPLE_DIV=4 and PHASE_W=24, so one saw step of
// 0x080000 is 64 LSBs of value. All stimulus is driven on falling edges, and
// all outputs are sampled on falling edges.

module tb_tone_gen;

  localparam int SD = 4;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] freq_word = '0;
  logic          freq_load = 1'b0;
  logic [1:0]    wave_sel = 2'd1;
  logic [8:0]    amp = 9'd256;
  logic          enable = 1'b1;
  logic [10:0]   value;
  logic          sample_tick;

  int checks   = 0;
  int failures = 0;
  int last_n   = 0;

  tone_gen #(.SAMPLE_DIV(SD), .PHASE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .freq_word   (freq_word),
    .freq_load   (freq_load),
    .wave_sel    (wave_sel),
    .amp         (amp),
    .enable      (enable),
    .value       (value),
    .sample_tick (sample_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance falling edges until sample_tick is seen, with a bounded wait. The
  // number of edges that were waited is left in last_n.
  task automatic wait_sample(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 4 * SD + 8);
    last_n = n;
    chk({tag, "_tick"}, int'(sample_tick), 1);
  endtask

  task automatic next_sample(input string tag, input int exp);
    wait_sample(tag);
    chk(tag, int'(value), exp);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] l;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_value", int'(value), 1024);
    chk("rst_tick", int'(sample_tick), 0);

    // Saw ramp: load 0x080000 once, then step 64 per sample and wrap after 1984.
    rst = 1'b0;
    freq_word = 24'h080000;
    freq_load = 1'b1;
    @(negedge clk);
    freq_load = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      next_sample("saw", (i * 64) % 2048);
      if (i > 1) chk("saw_period", last_n, SD);
    end
    for (int i = 1; i <= 10; i++) next_sample("saw2", i * 64);

    // Enable gating at value 640: midscale while the phase is held, then resume.
    enable = 1'b0;
    next_sample("dis0", 1024);
    next_sample("dis1", 1024);
    enable = 1'b1;
    next_sample("reen", 704);

    // Sample cycle has cnt=2. Three edges later is cnt=1, two cycles before the tick.
    repeat (3) @(negedge clk);
    freq_word = 24'h100000;
    freq_load = 1'b1;
    @(negedge clk);
    freq_load = 1'b0;
    // This falling edge is the sample from the tick before the load.
    chk("fl_a_tick", int'(sample_tick), 1);
    chk("fl_a", int'(value), 768);
    next_sample("fl_b", 896);
    next_sample("fl_c", 1024);

    // Load in the tick cycle itself: the old step of 128 is used once more.
    @(negedge clk);
    freq_word = 24'h080000;
    freq_load = 1'b1;
    @(negedge clk);
    freq_load = 1'b0;
    next_sample("ft_a", 1152);
    next_sample("ft_b", 1216);
    next_sample("ft_c", 1280);

    // Square with a half-cycle step, so that each sample alternates. The phase is now 0xA00000.
    freq_word = 24'h800000;
    freq_load = 1'b1;
    wave_sel  = 2'd0;
    amp       = 9'd128;
    @(negedge clk);
    freq_load = 1'b0;
    next_sample("sq128_a", 1535);
    next_sample("sq128_b", 512);
    next_sample("sq128_c", 1535);
    next_sample("sq128_d", 512);
    amp = 9'd400;
    next_sample("sq400_a", 2047);
    next_sample("sq400_b", 0);

    // Triangle: phase 0x200000 gives 512, and phase 0xA00000 folds to ~512 = 1535.
    wave_sel = 2'd2;
    amp      = 9'd256;
    next_sample("tri_a", 512);
    next_sample("tri_b", 1535);
    amp = 9'd0;
    next_sample("amp0", 1024);
    wave_sel = 2'd1;
    amp      = 9'd256;
    next_sample("saw_back", 1280);

    // Asynchronous reset between edges while sample_tick is high.
    #2 rst = 1'b1;
    #1;
    chk("rst_async_value", int'(value), 1024);
    chk("rst_async_tick", int'(sample_tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_sample("rst_restart");
    chk("rst_first_tick_edges", last_n, 6);
    chk("rst_restart_value", int'(value), 0);

    // Noise from reset: the first sample is lfsr 0x59C3, giving 718. Then follow the model.
    rst      = 1'b1;
    wave_sel = 2'd3;
    amp      = 9'd256;
    enable   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    next_sample("noise_first", 718);
    l = lfsr_next(16'hACE1);
    for (int i = 1; i < 1000; i++) begin
      l = lfsr_next(l);
      next_sample("noise", int'(l[15:5]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
